seq_lock_param: RTL and testbench

SEQ_LOCK_PARAM -- requirements
Module: seq_lock_param

---
 rtl/seq_lock_pkg.sv | 22 ++
 rtl/lock_timer.sv | 27 ++
 rtl/seq_lock_param.sv | 102 ++++++++++
 tb/tb_seq_lock_param.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seq_lock_pkg.sv
// seq_lock_pkg: shared state encoding and key-symbol extraction for seq_lock_param
package seq_lock_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } state_t;

    localparam int KEY_MAX_W = 256;

    // Symbol i of a key of key_len symbols; symbol 0 sits in the MSBs.
    function automatic logic [31:0] key_sym(input logic [KEY_MAX_W-1:0] key,
                                            input int sym_w,
                                            input int key_len,
                                            input int i);
        logic [KEY_MAX_W-1:0] mask;
        mask = (KEY_MAX_W'(1) << sym_w) - KEY_MAX_W'(1);
        return 32'((key >> (sym_w * (key_len - 1 - i))) & mask);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// lock_timer: lockout down-counter; load presets LOCKOUT_CYC-1, done is high at zero
// Ports: clk, rst (async active-high), load (preset counter), done (counter is zero)
module lock_timer #(
    parameter int LOCKOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int CW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load ? CW'(LOCKOUT_CYC - 1) : ((cnt_q != '0) ? cnt_q - 1'b1 : cnt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/seq_lock_param.sv
// seq_lock_param: symbol-sequence lock with failed-attempt lockout
// Ports: clk, rst (async active-high), sym_valid/sym (symbol input), relock (leave UNLOCKED),
//        unlock, lockout (registered state flags), fail_cnt, progress (registered counters)
module seq_lock_param
    import seq_lock_pkg::*;
#(
    parameter int                          SYM_W       = 2,
    parameter int                          KEY_LEN     = 6,
    parameter logic [SYM_W*KEY_LEN-1:0]    KEY         = 12'b011001100101,
    parameter int                          MAX_FAIL    = 3,
    parameter int                          LOCKOUT_CYC = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sym_valid,
    input  logic [SYM_W-1:0]                   sym,
    input  logic                               relock,
    output logic                               unlock,
    output logic                               lockout,
    output logic [$clog2(MAX_FAIL+1)-1:0]      fail_cnt,
    output logic [$clog2(KEY_LEN+1)-1:0]       progress
);

    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int PW = $clog2(KEY_LEN + 1);

    state_t        state_q, state_d;
    logic [PW-1:0] progress_q, progress_d;
    logic [FW-1:0] fail_q, fail_d;
    logic          unlock_q, unlock_d;
    logic          lockout_q, lockout_d;
    logic          match;
    logic          load;
    logic          done;

    lock_timer #(.LOCKOUT_CYC(LOCKOUT_CYC)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .done (done)
    );

    always_comb begin
        state_d    = state_q;
        progress_d = progress_q;
        fail_d     = fail_q;
        load       = 1'b0;
        match      = key_sym(KEY_MAX_W'(KEY), SYM_W, KEY_LEN, int'(progress_q)) == 32'(sym);
        case (state_q)
            IDLE: begin
                if (sym_valid && match) begin
                    if (progress_q == PW'(KEY_LEN - 1)) begin
                        state_d    = UNLOCKED;
                        progress_d = '0;
                        fail_d     = '0;
                    end else begin
                        progress_d = progress_q + 1'b1;
                    end
                end else if (sym_valid) begin
                    progress_d = '0;
                    fail_d     = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;
                    if (fail_q + 1'b1 == FW'(MAX_FAIL)) begin
                        state_d = LOCKOUT;
                        load    = 1'b1;
                    end
                end
            end
            UNLOCKED: state_d = relock ? IDLE : UNLOCKED;
            LOCKOUT: begin
                if (done) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        unlock_d  = (state_d == UNLOCKED);
        lockout_d = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            progress_q <= '0;
            fail_q     <= '0;
            unlock_q   <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            progress_q <= progress_d;
            fail_q     <= fail_d;
            unlock_q   <= unlock_d;
            lockout_q  <= lockout_d;
        end
    end

    assign unlock   = unlock_q;
    assign lockout  = lockout_q;
    assign fail_cnt = fail_q;
    assign progress = progress_q;

endmodule

// File: tb/tb_seq_lock_param.sv
// tb_seq_lock_param: directed scoreboard bench for seq_lock_param with default parameters
module tb_seq_lock_param;

    typedef struct {
        logic       u;
        logic       l;
        logic [1:0] f;
        logic [2:0] p;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sym_valid = 1'b0;
    logic [1:0] sym = 2'd0;
    logic       relock = 1'b0;
    logic       unlock;
    logic       lockout;
    logic [1:0] fail_cnt;
    logic [2:0] progress;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic [1:0] k [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01};

    seq_lock_param dut (
        .clk       (clk),
        .rst       (rst),
        .sym_valid (sym_valid),
        .sym       (sym),
        .relock    (relock),
        .unlock    (unlock),
        .lockout   (lockout),
        .fail_cnt  (fail_cnt),
        .progress  (progress)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Monitor: compares the post-edge outputs against the expectation queued for that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if ({unlock, lockout, fail_cnt, progress} !== {e.u, e.l, e.f, e.p}) begin
                    errors++;
                    $display("FAIL %s got u=%b l=%b f=%0d p=%0d exp u=%b l=%b f=%0d p=%0d",
                             e.nm, unlock, lockout, fail_cnt, progress, e.u, e.l, e.f, e.p);
                end
            end
        end
    end

    task automatic step(input logic v, input logic [1:0] s, input logic rl,
                        input logic eu, input logic el, input logic [1:0] ef,
                        input logic [2:0] ep, input string nm);
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        sym_valid = v;
        sym = s;
        relock = rl;
        e.u = eu; e.l = el; e.f = ef; e.p = ep; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic enter_key(input logic [1:0] f0, input string nm);
        for (int i = 0; i < 6; i++)
            step(1'b1, k[i], 1'b0, i == 5, 1'b0, (i == 5) ? 2'd0 : f0,
                 (i == 5) ? 3'd0 : 3'(i + 1), nm);
    endtask

    task automatic async_rst(input string nm);
        @(negedge clk);
        sym_valid = 1'b0;
        relock = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({unlock, lockout, fail_cnt, progress} !== 7'd0) begin
            errors++;
            $display("FAIL %s got u=%b l=%b f=%0d p=%0d exp all zero",
                     nm, unlock, lockout, fail_cnt, progress);
        end
        @(posedge clk);
    endtask

    initial begin
        #3;
        checks++;
        if ({unlock, lockout, fail_cnt, progress} !== 7'd0) begin
            errors++;
            $display("FAIL reset got u=%b l=%b f=%0d p=%0d exp all zero",
                     unlock, lockout, fail_cnt, progress);
        end
        // Back-to-back correct key, then hold and relock
        enter_key(2'd0, "key_b2b");
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, "unlock_hold");
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, "relock");
        // Key with a 3-cycle gap between symbols 3 and 4
        step(1'b1, k[0], 1'b0, 1'b0, 1'b0, 2'd0, 3'd1, "gap_s1");
        step(1'b1, k[1], 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, "gap_s2");
        step(1'b1, k[2], 1'b0, 1'b0, 1'b0, 2'd0, 3'd3, "gap_s3");
        for (int i = 0; i < 3; i++)
            step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'd0, 3'd3, "gap_idle");
        step(1'b1, k[3], 1'b0, 1'b0, 1'b0, 2'd0, 3'd4, "gap_s4");
        step(1'b1, k[4], 1'b0, 1'b0, 1'b0, 2'd0, 3'd5, "gap_s5");
        step(1'b1, k[5], 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, "gap_s6");
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, "gap_relock");
        // Partial match then wrong symbol, then the full key
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1, "bad_p1");
        step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, "bad_p2");
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, "bad_miss");
        enter_key(2'd1, "key_after_miss");
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, "unlocked_ignore_sym");
        step(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, "relock_with_sym");
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, "relock_in_idle");
        // Three failures -> lockout for exactly 16 cycles; key and relock ignored inside
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, "fail1");
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd2, 3'd0, "fail2");
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'd3, 3'd0, "fail3_lock");
        for (int i = 0; i < 16; i++)
            step(1'b1, k[i % 6], (i % 4) == 0, 1'b0, i < 15, (i < 15) ? 2'd3 : 2'd0, 3'd0,
                 (i < 15) ? "lockout_hold" : "lockout_exit");
        enter_key(2'd0, "key_after_lockout");
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, "relock2");
        // Async reset mid-sequence
        for (int i = 0; i < 4; i++)
            step(1'b1, k[i], 1'b0, 1'b0, 1'b0, 2'd0, 3'(i + 1), "pre_rst");
        async_rst("rst_mid_seq");
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1, "post_rst_s5");
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, "post_rst_s6");
        enter_key(2'd1, "key_after_rst");
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, "relock3");
        // Async reset mid-lockout
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, "lf1");
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 2'd2, 3'd0, "lf2");
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 2'd3, 3'd0, "lf3");
        for (int i = 0; i < 3; i++)
            step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'd3, 3'd0, "lf_hold");
        async_rst("rst_mid_lockout");
        enter_key(2'd0, "key_after_lock_rst");
        @(negedge clk);
        sym_valid = 1'b0;
        relock = 1'b0;
        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
